// File: rtl/lms_rx_iq_deframer_pkg.sv
// Shared types and constants for the LMS6002D RX I/Q deframer.
package lms_rx_iq_deframer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t HUNT   = 2'd0;
  localparam state_t GOT_I  = 2'd1;
  localparam state_t WAIT_I = 2'd2;

  localparam int ERR_W    = 16;
  localparam int SAMPLE_W = 12;

  typedef struct packed {
    logic [SAMPLE_W-1:0] i;
    logic [SAMPLE_W-1:0] q;
  } iq_pair_t;

endpackage

// File: rtl/iq_pair_fifo.sv
// Show-ahead synchronous FIFO for I/Q pairs; extra pointer MSB separates full from empty.
module iq_pair_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (do_pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/lms_rx_iq_deframer.sv
// Pairs interleaved LMS6002D ADC words into I/Q samples, checks framing and buffers pairs.
module lms_rx_iq_deframer
  import lms_rx_iq_deframer_pkg::*;
#(
  parameter int   WIDTH      = SAMPLE_W,
  parameter int   FIFO_DEPTH = 4,
  parameter logic IQSEL_I    = 1'b1,
  parameter int   LOCK_PAIRS = 4
) (
  input  logic             lms_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             swap_iq,
  input  logic             clr_count,
  input  logic             rx_iqsel,
  input  logic [WIDTH-1:0] rx_d,
  output logic [WIDTH-1:0] out_i,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overflow,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  localparam int LW = $clog2(LOCK_PAIRS + 1);

  logic [WIDTH-1:0]   d_q, held_q, held_d;
  logic               sel_q, sel_prev_q;
  state_t             state_q, state_d;
  logic [LW-1:0]      lock_q, lock_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               frame_err_q, overflow_q;
  logic               is_i, is_edge, push_req, err_ev, ovf_ev;
  logic               fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] fifo_din, fifo_dout;

  // sel_prev_q resets to the I level so a fresh Q word is needed before the first pair.
  assign is_i    = (sel_q == IQSEL_I);
  assign is_edge = is_i && (sel_prev_q != IQSEL_I);

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    push_req = 1'b0;
    err_ev   = 1'b0;
    if (!enable) begin
      state_d = HUNT;
      held_d  = '0;
    end else begin
      case (state_q)
        HUNT: if (is_edge) begin
          held_d  = d_q;
          state_d = GOT_I;
        end
        GOT_I: if (is_i) begin
          err_ev = 1'b1;
          held_d = d_q;
        end else begin
          push_req = 1'b1;
          state_d  = WAIT_I;
        end
        WAIT_I: if (is_i) begin
          held_d  = d_q;
          state_d = GOT_I;
        end else begin
          err_ev  = 1'b1;
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (!enable || err_ev)                               lock_d = '0;
    else if (push_req && (lock_q != LW'(LOCK_PAIRS)))    lock_d = lock_q + LW'(1);
    err_cnt_d = err_cnt_q;
    if (clr_count)                        err_cnt_d = '0;
    else if (err_ev && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  assign ovf_ev   = push_req && fifo_full && !out_ready;
  assign fifo_din = swap_iq ? {d_q, held_q} : {held_q, d_q};

  always_ff @(posedge lms_clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q         <= '0;
      sel_q       <= IQSEL_I;
      sel_prev_q  <= IQSEL_I;
      state_q     <= HUNT;
      held_q      <= '0;
      lock_q      <= '0;
      err_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      d_q         <= rx_d;
      sel_q       <= rx_iqsel;
      sel_prev_q  <= sel_q;
      state_q     <= state_d;
      held_q      <= held_d;
      lock_q      <= lock_d;
      err_cnt_q   <= err_cnt_d;
      frame_err_q <= err_ev;
      overflow_q  <= ovf_ev;
    end
  end

  iq_pair_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (lms_clk),
    .rst_ni  (rst_n),
    .flush_i (!enable),
    .push_i  (push_req),
    .pop_i   (out_ready),
    .data_i  (fifo_din),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_i     = fifo_dout[2*WIDTH-1:WIDTH];
  assign out_q     = fifo_dout[WIDTH-1:0];
  assign out_valid = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign err_count = err_cnt_q;
  assign locked    = (lock_q == LW'(LOCK_PAIRS));

endmodule

// File: tb/tb_lms_rx_iq_deframer.sv
// Directed bench for lms_rx_iq_deframer with hand-computed expectations.
module tb_lms_rx_iq_deframer;

  logic        lms_clk = 1'b0;
  logic        rst_n, enable, swap_iq, clr_count, rx_iqsel, out_ready;
  logic [11:0] rx_d, out_i, out_q;
  logic        out_valid, frame_err, overflow, locked;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  lms_rx_iq_deframer dut (
    .lms_clk   (lms_clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .swap_iq   (swap_iq),
    .clr_count (clr_count),
    .rx_iqsel  (rx_iqsel),
    .rx_d      (rx_d),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .err_count (err_count),
    .locked    (locked)
  );

  always #5 lms_clk = ~lms_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic sel, input logic [11:0] d);
    rx_iqsel = sel;
    rx_d     = d;
    @(posedge lms_clk);
    #1;
  endtask

  task automatic send_i(input logic [11:0] d); put(1'b1, d); endtask
  task automatic send_q(input logic [11:0] d); put(1'b0, d); endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; swap_iq = 1'b0; clr_count = 1'b0;
    rx_iqsel = 1'b1; rx_d = '0; out_ready = 1'b1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_locked", locked, 0);
    rst_n = 1'b1;

    // leading I without a prior Q must not open a pair
    send_i(12'h777);
    send_q(12'h888);
    for (int p = 0; p < 6; p++) begin
      send_i(12'h123);
      if (p == 0) chk("no_pair_without_q", out_valid, 0);
      else begin
        chk("clean_valid", out_valid, 1);
        chk("clean_i", out_i, 12'h123);
        chk("clean_q", out_q, 12'hABC);
        chk("clean_locked", locked, (p >= 4) ? 1 : 0);
      end
      chk("clean_ferr", frame_err, 0);
      send_q(12'hABC);
      if (p >= 1) chk("clean_pop", out_valid, 0);
    end

    // doubled I
    send_i(12'h001);
    send_i(12'h002);
    send_q(12'h003);
    chk("dbl_i_ferr", frame_err, 1);
    chk("dbl_i_cnt", err_count, 1);
    chk("dbl_i_lock", locked, 0);
    send_i(12'h123);
    chk("dbl_i_ferr_pulse", frame_err, 0);
    chk("dbl_i_valid", out_valid, 1);
    chk("dbl_i_out_i", out_i, 12'h002);
    chk("dbl_i_out_q", out_q, 12'h003);

    // doubled Q
    send_q(12'hABC);
    send_q(12'hABC);
    chk("dq_pair_i", out_i, 12'h123);
    send_q(12'h555);
    chk("dq_ferr", frame_err, 1);
    chk("dq_cnt", err_count, 2);
    send_i(12'h456);
    chk("dq_hunt_valid", out_valid, 0);
    send_q(12'h789);
    send_i(12'h123);
    chk("dq_resync_valid", out_valid, 1);
    chk("dq_resync_i", out_i, 12'h456);
    chk("dq_resync_q", out_q, 12'h789);
    send_q(12'hABC);
    chk("dq_drained", out_valid, 0);

    // backpressure: six pairs into a four-deep FIFO
    out_ready = 1'b0;
    send_i(12'h101);
    for (int n = 1; n <= 5; n++) begin
      send_q(12'h200 + 12'(n));
      if (n >= 2) chk("bp_ovf_pulse", overflow, 0);
      send_i(12'h101 + 12'(n));
      chk("bp_ovf", overflow, (n >= 4) ? 1 : 0);
      chk("bp_head_i", out_i, 12'h123);
      chk("bp_head_q", out_q, 12'hABC);
    end
    chk("bp_errcnt", err_count, 2);

    // full FIFO with push and pop on the same edge
    send_q(12'h2AA);
    chk("fp_still_full_head", out_i, 12'h123);
    out_ready = 1'b1;
    send_i(12'h1BB);
    chk("fp_ovf", overflow, 0);
    chk("fp_head_i", out_i, 12'h101);
    chk("fp_head_q", out_q, 12'h201);
    send_q(12'h2BB);
    chk("drain2_i", out_i, 12'h102);
    chk("drain2_q", out_q, 12'h202);
    send_i(12'h123);
    chk("drain3_i", out_i, 12'h103);
    chk("drain3_q", out_q, 12'h203);
    send_q(12'hABC);
    chk("drain4_i", out_i, 12'h106);
    chk("drain4_q", out_q, 12'h2AA);
    chk("drain_ferr", frame_err, 0);

    // swap
    swap_iq = 1'b1;
    send_i(12'h123);
    chk("drain5_i", out_i, 12'h1BB);
    send_q(12'hABC);
    chk("swap_i", out_i, 12'hABC);
    chk("swap_q", out_q, 12'h123);
    swap_iq = 1'b0;
    send_i(12'h124);
    chk("noswap_i", out_i, 12'h123);
    chk("noswap_q", out_q, 12'hABC);

    // clear coincident with an error
    send_i(12'h125);
    clr_count = 1'b1;
    send_q(12'hABC);
    clr_count = 1'b0;
    chk("clr_ferr", frame_err, 1);
    chk("clr_cnt", err_count, 0);

    // relock, then drop enable for one cycle
    for (int k = 0; k < 5; k++) begin
      send_i(12'h123);
      send_q(12'hABC);
    end
    chk("relock", locked, 1);
    out_ready = 1'b0;
    send_i(12'h123);
    chk("en_pre_valid", out_valid, 1);
    enable = 1'b0;
    send_q(12'hABC);
    chk("en_valid", out_valid, 0);
    chk("en_locked", locked, 0);
    chk("en_ferr", frame_err, 0);
    enable = 1'b1;
    out_ready = 1'b1;
    send_i(12'h123);
    send_q(12'hABC);
    chk("post_en_no_early", out_valid, 0);
    send_i(12'h123);
    chk("post_en_valid", out_valid, 1);
    chk("post_en_i", out_i, 12'h123);

    // reset mid-operation
    out_ready = 1'b0;
    send_q(12'hABC);
    send_i(12'h123);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out_i", out_i, 0);
    chk("mid_rst_locked", locked, 0);
    rst_n = 1'b1;
    send_q(12'hABC);
    send_i(12'h123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
